vga_frame_scheduler: RTL and testbench

Generates 640x480@60 VGA raster timing (column, row, display_enable, syncs) for FinalProjectVgaLogic on vga_clock. It also schedules when game logic may update the sprite positions, background, lives and number inputs the renderer reads. Updates are granted only inside vertical blanking, so a frame never tears. It sits between the game-state FSM and the renderer and is the only source of row, column and display_enable.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_frame_scheduler_if.sv | 33 +++
 rtl/vga_raster_counter.sv | 64 ++++++
 rtl/vga_frame_scheduler.sv | 131 +++++++++++++
 tb/tb_vga_frame_scheduler.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 640x480@60 timing constants, tile geometry and grant FSM states.
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int c_H_VISIBLE     = 640;
    localparam int c_H_FRONT       = 16;
    localparam int c_H_SYNC        = 96;
    localparam int c_H_BACK        = 48;
    localparam int c_V_VISIBLE     = 480;
    localparam int c_V_FRONT       = 10;
    localparam int c_V_SYNC        = 2;
    localparam int c_V_BACK        = 33;
    localparam int c_GRANT_GUARD   = 1;

    localparam int c_H_TOTAL       = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_V_TOTAL       = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    localparam int c_BLOCK_WIDTH   = 40;
    localparam int c_SCREEN_WIDTH  = c_H_VISIBLE;
    localparam int c_SCREEN_HEIGHT = c_V_VISIBLE;

    localparam int c_FRAME_COUNT_W = 16;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        GRANT = 2'd1,
        SPENT = 2'd2
    } grant_state_t;

    // Inclusive range test used by every sync/window decode.
    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_scheduler_if
// Brief    : Raster position/qualifier bus plus the update request/grant pair.
// Revision : 1.0
// ============================================================================
interface vga_frame_scheduler_if;

    int          column;
    int          row;
    logic        display_enable;
    logic        h_sync;
    logic        v_sync;
    logic        vblank;
    logic        frame_tick;
    logic        update_req;
    logic        update_ack;
    logic [15:0] frame_count;

    modport master (
        output column, row, display_enable, h_sync, v_sync, vblank,
               frame_tick, update_ack, frame_count,
        input  update_req
    );

    modport slave (
        input  column, row, display_enable, h_sync, v_sync, vblank,
               frame_tick, update_ack, frame_count,
        output update_req
    );

endinterface
`default_nettype wire

// File: rtl/vga_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_raster_counter
// Brief    : Column/row/frame counters with line and frame wrap detection.
// Revision : 1.0
// ============================================================================
module vga_raster_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = c_H_TOTAL,
    parameter int V_TOTAL = c_V_TOTAL,
    parameter int COL_W   = $clog2(H_TOTAL),
    parameter int ROW_W   = $clog2(V_TOTAL)
) (
    input  wire logic                       vga_clock,
    input  wire logic                       reset,
    output logic [COL_W-1:0]                o_column,
    output logic [ROW_W-1:0]                o_row,
    output logic [COL_W-1:0]                o_next_column,
    output logic [ROW_W-1:0]                o_next_row,
    output logic [c_FRAME_COUNT_W-1:0]      o_frame_count
);

    logic [COL_W-1:0]           r_column;
    logic [ROW_W-1:0]           r_row;
    logic [c_FRAME_COUNT_W-1:0] r_frame_count;

    logic                       w_line_wrap;
    logic                       w_frame_wrap;
    logic [COL_W-1:0]           w_next_column;
    logic [ROW_W-1:0]           w_next_row;

    always_comb begin
        w_line_wrap   = (r_column == COL_W'(H_TOTAL - 1));
        w_frame_wrap  = w_line_wrap && (r_row == ROW_W'(V_TOTAL - 1));
        w_next_column = w_line_wrap ? '0 : r_column + 1'b1;
        w_next_row    = r_row;
        if (w_line_wrap) begin
            w_next_row = w_frame_wrap ? '0 : r_row + 1'b1;
        end
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_column      <= '0;
            r_row         <= '0;
            r_frame_count <= '0;
        end else begin
            r_column <= w_next_column;
            r_row    <= w_next_row;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    assign o_column      = r_column;
    assign o_row         = r_row;
    assign o_next_column = w_next_column;
    assign o_next_row    = w_next_row;
    assign o_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: rtl/vga_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_scheduler
// Brief    : VGA raster timing plus a one-grant-per-frame vblank update arbiter.
// Revision : 1.0
// ============================================================================
module vga_frame_scheduler
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = c_H_VISIBLE,
    parameter int H_FRONT     = c_H_FRONT,
    parameter int H_SYNC      = c_H_SYNC,
    parameter int H_BACK      = c_H_BACK,
    parameter int V_VISIBLE   = c_V_VISIBLE,
    parameter int V_FRONT     = c_V_FRONT,
    parameter int V_SYNC      = c_V_SYNC,
    parameter int V_BACK      = c_V_BACK,
    parameter int GRANT_GUARD = c_GRANT_GUARD
) (
    input  wire logic              vga_clock,
    input  wire logic              reset,
    vga_frame_scheduler_if.master  bus
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int COL_W    = $clog2(H_TOTAL);
    localparam int ROW_W    = $clog2(V_TOTAL);
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int WIN_LO   = V_VISIBLE;
    localparam int WIN_HI   = V_TOTAL - 1 - GRANT_GUARD;

    logic [COL_W-1:0]           w_column;
    logic [ROW_W-1:0]           w_row;
    logic [COL_W-1:0]           w_next_column;
    logic [ROW_W-1:0]           w_next_row;
    logic [c_FRAME_COUNT_W-1:0] w_frame_count;

    logic                       r_display_enable;
    logic                       r_h_sync;
    logic                       r_v_sync;
    logic                       r_vblank;
    logic                       r_frame_tick;
    logic                       r_update_ack;
    grant_state_t               r_state;

    logic                       w_window;
    logic                       w_frame_start;

    vga_raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_raster (
        .vga_clock     (vga_clock),
        .reset         (reset),
        .o_column      (w_column),
        .o_row         (w_row),
        .o_next_column (w_next_column),
        .o_next_row    (w_next_row),
        .o_frame_count (w_frame_count)
    );

    // Qualifiers are decoded from the position the counters are about to
    // load, so they land in the same cycle as the matching column/row.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_display_enable <= 1'b1;
            r_h_sync         <= 1'b1;
            r_v_sync         <= 1'b1;
            r_vblank         <= 1'b0;
            r_frame_tick     <= 1'b0;
        end else begin
            r_display_enable <= (int'(w_next_column) < H_VISIBLE) &&
                                (int'(w_next_row) < V_VISIBLE);
            r_h_sync         <= !in_range(int'(w_next_column), HS_START, HS_END);
            r_v_sync         <= !in_range(int'(w_next_row), VS_START, VS_END);
            r_vblank         <= (int'(w_next_row) >= V_VISIBLE);
            r_frame_tick     <= (int'(w_next_row) == V_VISIBLE) && (w_next_column == '0);
        end
    end

    assign w_window      = in_range(int'(w_row), WIN_LO, WIN_HI);
    assign w_frame_start = (w_column == '0) && (w_row == '0);

    // SPENT holds until the next active frame begins, which caps the grant
    // rate at one per frame even with a request held permanently high.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ARMED;
            r_update_ack <= 1'b0;
        end else begin
            r_update_ack <= 1'b0;
            case (r_state)
                ARMED: begin
                    if (w_window && bus.update_req) begin
                        r_state      <= GRANT;
                        r_update_ack <= 1'b1;
                    end
                end
                GRANT: begin
                    r_state <= SPENT;
                end
                SPENT: begin
                    if (w_frame_start) begin
                        r_state <= ARMED;
                    end
                end
                default: begin
                    r_state <= ARMED;
                end
            endcase
        end
    end

    assign bus.column         = int'(w_column);
    assign bus.row            = int'(w_row);
    assign bus.frame_count    = w_frame_count;
    assign bus.display_enable = r_display_enable;
    assign bus.h_sync         = r_h_sync;
    assign bus.v_sync         = r_v_sync;
    assign bus.vblank         = r_vblank;
    assign bus.frame_tick     = r_frame_tick;
    assign bus.update_ack     = r_update_ack;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_scheduler
// Brief    : Self-checking bench on a reduced raster with a grant scoreboard.
// Revision : 1.0
// ============================================================================
module tb_vga_frame_scheduler;

    localparam int H_VIS = 16;
    localparam int H_FP  = 2;
    localparam int H_SY  = 4;
    localparam int H_BP  = 3;
    localparam int V_VIS = 12;
    localparam int V_FP  = 2;
    localparam int V_SY  = 2;
    localparam int V_BP  = 3;
    localparam int GUARD = 1;
    localparam int H_TOT = H_VIS + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SY + V_BP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int m_col = 0;
    int m_row = 0;
    int m_fc  = 0;
    int de_cnt = 0;
    int hs_cnt = 0;
    longint exp_q[$];

    vga_frame_scheduler_if bus();

    vga_frame_scheduler #(
        .H_VISIBLE   (H_VIS),
        .H_FRONT     (H_FP),
        .H_SYNC      (H_SY),
        .H_BACK      (H_BP),
        .V_VISIBLE   (V_VIS),
        .V_FRONT     (V_FP),
        .V_SYNC      (V_SY),
        .V_BACK      (V_BP),
        .GRANT_GUARD (GUARD)
    ) u_dut (
        .vga_clock (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint pos_key(input int f, input int r, input int c);
        return longint'(f) * 1000000 + longint'(r) * 1000 + longint'(c);
    endfunction

    task automatic observe();
        logic [4:0] exp_flags;
        logic [4:0] got_flags;
        exp_flags = {(m_col < H_VIS) && (m_row < V_VIS),
                     !((m_col >= H_VIS + H_FP) && (m_col < H_VIS + H_FP + H_SY)),
                     !((m_row >= V_VIS + V_FP) && (m_row < V_VIS + V_FP + V_SY)),
                     (m_row >= V_VIS),
                     (m_row == V_VIS) && (m_col == 0)};
        got_flags = {bus.display_enable, bus.h_sync, bus.v_sync, bus.vblank, bus.frame_tick};
        chk("column", bus.column, m_col);
        chk("row", bus.row, m_row);
        chk("flags", got_flags, exp_flags);
        chk("frame_count", bus.frame_count, m_fc);
        if (bus.update_ack) begin
            if (exp_q.size() > 0) chk("ack_pos", pos_key(m_fc, m_row, m_col), exp_q.pop_front());
            else                  chk("ack_spurious", pos_key(m_fc, m_row, m_col), -1);
        end
        hs_cnt += int'(!bus.h_sync);
        de_cnt += int'(bus.display_enable);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        m_col++;
        if (m_col == H_TOT) begin
            m_col = 0;
            m_row++;
            if (m_row == V_TOT) begin
                m_row = 0;
                m_fc  = (m_fc + 1) & 16'hFFFF;
            end
        end
        if (m_col == 0) begin
            chk("hsync_width", hs_cnt, H_SY);
            hs_cnt = 0;
        end
        if (m_col == 0 && m_row == 0) begin
            chk("de_per_frame", de_cnt, H_VIS * V_VIS);
            de_cnt = 0;
        end
        observe();
    endtask

    task automatic run_until(input int f, input int r, input int c);
        int guard;
        guard = 0;
        while (!(m_fc == f && m_row == r && m_col == c) && guard < 4 * H_TOT * V_TOT) begin
            step();
            guard++;
        end
        if (guard >= 4 * H_TOT * V_TOT) chk("run_until_bound", guard, 0);
    endtask

    initial begin
        bus.update_req = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ack", bus.update_ack, 0);
        observe();
        @(negedge clk);
        rst_n = 1'b1;

        // Request held from active video: one ack per frame at window open.
        run_until(0, 3, 0);
        bus.update_req = 1'b1;
        exp_q.push_back(pos_key(0, V_VIS, 1));
        exp_q.push_back(pos_key(1, V_VIS, 1));
        run_until(1, V_VIS + 2, 0);
        bus.update_req = 1'b0;

        // Request raised in the guard line waits for the next frame.
        run_until(2, V_TOT - 1, 10);
        bus.update_req = 1'b1;
        exp_q.push_back(pos_key(3, V_VIS, 1));
        run_until(3, V_VIS + 2, 0);
        bus.update_req = 1'b0;

        // Request withdrawn before the window: never granted.
        run_until(4, 2, 0);
        bus.update_req = 1'b1;
        run_until(4, 5, 0);
        bus.update_req = 1'b0;

        // Reset while the grant is being issued.
        run_until(5, 3, 0);
        bus.update_req = 1'b1;
        exp_q.push_back(pos_key(5, V_VIS, 1));
        run_until(5, V_VIS, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_ack", bus.update_ack, 0);
        m_col = 0;
        m_row = 0;
        m_fc  = 0;
        hs_cnt = 0;
        de_cnt = 0;
        observe();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(pos_key(0, V_VIS, 1));
        run_until(0, V_VIS + 2, 0);
        bus.update_req = 1'b0;
        run_until(2, 0, 5);

        chk("ack_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
